// File: rtl/icache_refill_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-cache refill controller.
package icache_refill_ctrl_pkg;

  localparam int REQ_DEPTH      = 4;
  localparam int LINE_SIZE      = 512;
  localparam int BEAT_WIDTH     = 64;
  localparam int OFFSET_WIDTH   = 6;
  localparam int BEATS          = LINE_SIZE / BEAT_WIDTH;
  localparam int ADDR_WIDTH     = 64;
  localparam int BEAT_CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_RESP = 2'd3
  } refill_state_e;

  // Clears the line-offset bits so every burst starts on a line boundary.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int offset_width);
    logic [63:0] mask;
    mask = (64'd1 << offset_width) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; holds pending miss addresses.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: queues line misses, issues one burst read at
// a time, assembles the returned beats into a line and hands it back to the icache.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | nothing in flight; pops the queue head when one exists
// ST_REQ  | burst read request presented to memory
// ST_RECV | accepting beats into the line buffer
// ST_RESP | completed line presented to the icache
module icache_refill_ctrl #(
  parameter int REQ_DEPTH    = icache_refill_ctrl_pkg::REQ_DEPTH,
  parameter int LINE_SIZE    = icache_refill_ctrl_pkg::LINE_SIZE,
  parameter int BEAT_WIDTH   = icache_refill_ctrl_pkg::BEAT_WIDTH,
  parameter int OFFSET_WIDTH = icache_refill_ctrl_pkg::OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_miss_valid_i,
  output logic                  icache_miss_ready_o,
  input  logic [63:0]           icache_miss_addr_i,
  output logic                  refill_icache_valid_o,
  input  logic                  refill_icache_ready_i,
  output logic [LINE_SIZE-1:0]  refill_icache_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [63:0]           mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BEAT_WIDTH-1:0] mem_resp_data_i,
  input  logic                  mem_resp_last_i,
  output logic                  mem_resp_ready_o,
  output logic                  burst_err_o
);

  import icache_refill_ctrl_pkg::*;

  localparam int BEATS = LINE_SIZE / BEAT_WIDTH;
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(BEATS - 1);

  refill_state_e              state;
  logic [63:0]                work_addr;
  logic [LINE_SIZE-1:0]       line_buf;
  logic [BEAT_CNT_WIDTH-1:0]  beat_cnt;
  logic                       burst_err;

  logic                       q_full;
  logic                       q_empty;
  logic                       q_pop;
  logic                       miss_push;
  logic [63:0]                q_head;
  logic [63:0]                miss_line_addr;
  logic                       last_beat;

  assign miss_line_addr      = line_align(icache_miss_addr_i, OFFSET_WIDTH);
  assign icache_miss_ready_o = !q_full;
  assign miss_push           = icache_miss_valid_i && !q_full;
  assign last_beat           = (beat_cnt == LAST_BEAT);

  // The head leaves the queue on the same edge the FSM moves into ST_REQ.
  assign q_pop = !q_empty &&
                 ((state == ST_IDLE) || ((state == ST_RESP) && refill_icache_ready_i));

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (miss_push),
    .push_data (miss_line_addr),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      work_addr <= '0;
      line_buf  <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (q_pop) begin
            work_addr <= q_head;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready_i) begin
            beat_cnt <= '0;
            state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (mem_resp_valid_i) begin
            line_buf[int'(beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_resp_data_i;
            // The beat count alone ends the burst; a misplaced last flag is only reported.
            if (mem_resp_last_i != last_beat) begin
              burst_err <= 1'b1;
            end
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (refill_icache_ready_i) begin
            if (q_pop) begin
              work_addr <= q_head;
              state     <= ST_REQ;
            end else begin
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_valid_o       = (state == ST_REQ);
  assign mem_req_addr_o        = work_addr;
  assign mem_resp_ready_o      = (state == ST_RECV);
  assign refill_icache_valid_o = (state == ST_RESP);
  assign refill_icache_data_o  = line_buf;
  assign burst_err_o           = burst_err;

endmodule
